// File: rtl/comparador_pkg.sv
// ---------------------------------------------------------------------------
// comparador_pkg
// Shared definitions for the MSB-first serial comparator:
//   state_t   : FSM state encoding (IDLE / SCAN / DONE)
//   WIDTH_DEF : default operand width
// ---------------------------------------------------------------------------
package comparador_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int WIDTH_DEF = 8;

endpackage : comparador_pkg

// File: rtl/celda_cmp_bit.sv
// ---------------------------------------------------------------------------
// celda_cmp_bit
// One-bit combinational compare cell.
// Ports:
//   a, b    : input bits
//   diff    : 1 when a != b
//   a_lt_b  : 1 when a = 0 and b = 1
// ---------------------------------------------------------------------------
module celda_cmp_bit (
   input  logic a,
   input  logic b,
   output logic diff,
   output logic a_lt_b
);

   assign diff   = a ^ b;
   assign a_lt_b = ~a & b;

endmodule : celda_cmp_bit

// File: rtl/comparador_izq_der.sv
// ---------------------------------------------------------------------------
// comparador_izq_der
// Serial unsigned comparator: scans wordA/wordB one bit per clock, MSB
// first, and reports A <= B (z) and A == B (eq) with a one-cycle done pulse.
// Ports:
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   start        : compare request, accepted in IDLE or DONE
//   wordA, wordB : operands, captured on an accepted start
//   z            : 1 when A <= B (held until the next done)
//   eq           : 1 when A == B (held until the next done)
//   busy         : high while scanning
//   done         : one-cycle pulse, z/eq valid from this cycle
// Configuration:
//   COMPARADOR_EARLY_EXIT_EN : when defined, finish at the first differing
//                              bit instead of always scanning WIDTH bits.
// ---------------------------------------------------------------------------
module comparador_izq_der
   import comparador_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] wordA,
   input  logic [WIDTH-1:0] wordB,
   output logic             z,
   output logic             eq,
   output logic             busy,
   output logic             done
);

`ifdef COMPARADOR_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   localparam int IW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0]    idx_q;
   logic             decided_q;
   logic             lta_q;
   logic             z_q, eq_q;

   logic             bit_diff, bit_lt;
   logic             start_ok;
   logic             first_diff;
   logic             dec_now, lta_now;

   celda_cmp_bit u_celda (
      .a      (a_q[idx_q]),
      .b      (b_q[idx_q]),
      .diff   (bit_diff),
      .a_lt_b (bit_lt)
   );

   assign start_ok   = start && (state_q != SCAN);
   assign first_diff = !decided_q && bit_diff;
   // Outcome including the bit being compared at this edge, so the result
   // is correct both for an early exit and for the final (index 0) bit.
   assign dec_now    = decided_q | bit_diff;
   assign lta_now    = decided_q ? lta_q : bit_lt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = SCAN;
         SCAN: if ((idx_q == '0) || (EARLY_EXIT && first_diff)) state_d = DONE;
         DONE: state_d = start ? SCAN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy = (state_q == SCAN);
      done = (state_q == DONE);
   end

   assign z  = z_q;
   assign eq = eq_q;

   // Operand, index and decision registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= '0;
         decided_q <= 1'b0;
         lta_q     <= 1'b0;
         z_q       <= 1'b0;
         eq_q      <= 1'b0;
      end else begin
         if (start_ok) begin
            a_q       <= wordA;
            b_q       <= wordB;
            idx_q     <= IW'(WIDTH - 1);
            decided_q <= 1'b0;
            lta_q     <= 1'b0;
         end else if (state_q == SCAN) begin
            if (first_diff) begin
               decided_q <= 1'b1;
               lta_q     <= bit_lt;
            end
            if (idx_q != '0) idx_q <= idx_q - 1'b1;
         end
         // Results only change on entry to DONE; a new start leaves them alone.
         if ((state_q == SCAN) && (state_d == DONE)) begin
            z_q  <= dec_now ? lta_now : 1'b1;
            eq_q <= !dec_now;
         end
      end
   end

endmodule : comparador_izq_der

// File: tb/tb_comparador_izq_der.sv
// ---------------------------------------------------------------------------
// tb_comparador_izq_der
// Two instances (WIDTH=8 and WIDTH=3) driven with directed and random
// traffic; a behavioural model predicts latency and results per request.
// ---------------------------------------------------------------------------
module tb_comparador_izq_der;

`ifdef COMPARADOR_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       start8, start3;
   logic [7:0] a8, b8;
   logic [2:0] a3, b3;
   logic       z8, eq8, busy8, done8;
   logic       z3, eq3, busy3, done3;

   int n_checks = 0;
   int n_fail   = 0;

   comparador_izq_der #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .wordA(a8), .wordB(b8),
      .z(z8), .eq(eq8), .busy(busy8), .done(done8)
   );

   comparador_izq_der #(.WIDTH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .wordA(a3), .wordB(b3),
      .z(z3), .eq(eq3), .busy(busy3), .done(done3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Edges from the start edge to the done cycle, from the operand values.
   function automatic int klat(input logic [7:0] a, input logic [7:0] b, input int w);
      int  k;
      bit  found;
      k = w;
      found = 1'b0;
      if (EE) begin
         for (int i = w - 1; i >= 0; i--) begin
            if (!found && (a[i] != b[i])) begin
               k = w - i;
               found = 1'b1;
            end
         end
      end
      return k;
   endfunction

   // ---------------- behavioural model ----------------
   logic       s_st [2];
   logic [7:0] s_a  [2];
   logic [7:0] s_b  [2];
   int         m_cnt [2];
   logic       m_done[2], m_z[2], m_eq[2], p_z[2], p_eq[2];

   assign s_st[0] = start8;
   assign s_a[0]  = a8;
   assign s_b[0]  = b8;
   assign s_st[1] = start3;
   assign s_a[1]  = {5'b0, a3};
   assign s_b[1]  = {5'b0, b3};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_cnt[i]  <= 0;
            m_done[i] <= 1'b0;
            m_z[i]    <= 1'b0;
            m_eq[i]   <= 1'b0;
            p_z[i]    <= 1'b0;
            p_eq[i]   <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_cnt[i] == 0) begin
               m_done[i] <= 1'b0;
               if (s_st[i]) begin
                  m_cnt[i] <= klat(s_a[i], s_b[i], (i == 0) ? 8 : 3);
                  p_z[i]   <= (s_a[i] <= s_b[i]);
                  p_eq[i]  <= (s_a[i] == s_b[i]);
               end
            end else begin
               m_cnt[i] <= m_cnt[i] - 1;
               if (m_cnt[i] == 1) begin
                  m_done[i] <= 1'b1;
                  m_z[i]    <= p_z[i];
                  m_eq[i]   <= p_eq[i];
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("busy8", 32'(busy8), 32'(m_cnt[0] != 0));
         chk("done8", 32'(done8), 32'(m_done[0]));
         chk("z8",    32'(z8),    32'(m_z[0]));
         chk("eq8",   32'(eq8),   32'(m_eq[0]));
         chk("busy3", 32'(busy3), 32'(m_cnt[1] != 0));
         chk("done3", 32'(done3), 32'(m_done[1]));
         chk("z3",    32'(z3),    32'(m_z[1]));
         chk("eq3",   32'(eq3),   32'(m_eq[1]));
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_z8"},    32'(z8),    0);
      chk({tag, "_eq8"},   32'(eq8),   0);
      chk({tag, "_busy8"}, 32'(busy8), 0);
      chk({tag, "_done8"}, 32'(done8), 0);
      chk({tag, "_z3"},    32'(z3),    0);
      chk({tag, "_done3"}, 32'(done3), 0);
   endtask

   // Issue one request on instance inst and check latency and result.
   task automatic go(input int inst, input logic [7:0] a, input logic [7:0] b,
                     input int k_exp, input logic z_exp, input logic eq_exp,
                     input string nm);
      int n;
      logic d, zz, ee;
      @(negedge clk);
      if (inst == 0) begin start8 = 1'b1; a8 = a; b8 = b; end
      else           begin start3 = 1'b1; a3 = a[2:0]; b3 = b[2:0]; end
      @(negedge clk);
      start8 = 1'b0;
      start3 = 1'b0;
      n = 0;
      d = (inst == 0) ? done8 : done3;
      while (!d && n < 40) begin
         @(negedge clk);
         n++;
         d = (inst == 0) ? done8 : done3;
      end
      zz = (inst == 0) ? z8 : z3;
      ee = (inst == 0) ? eq8 : eq3;
      if (n >= 40) begin
         chk({nm, "_timeout"}, 1, 0);
      end else begin
         chk({nm, "_latency"}, 32'(n), 32'(k_exp));
         chk({nm, "_z"}, 32'(zz), 32'(z_exp));
         chk({nm, "_eq"}, 32'(ee), 32'(eq_exp));
      end
   endtask

   initial begin
      int mode;
      rst_n  = 1'b1;
      start8 = 1'b0; start3 = 1'b0;
      a8 = '0; b8 = '0; a3 = '0; b3 = '0;
      #3 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Model pinned by hand-derived latencies
      chk("model_k_00", 32'(klat(8'h00, 8'h00, 8)), 8);
      chk("model_k_E7", 32'(klat(8'hE7, 8'h81, 8)), EE ? 2 : 8);
      chk("model_k_01", 32'(klat(8'h01, 8'h03, 8)), EE ? 7 : 8);

      go(0, 8'h00, 8'h00, 8, 1'b1, 1'b1, "a00_b00");
      go(0, 8'hE7, 8'h81, EE ? 2 : 8, 1'b0, 1'b0, "aE7_b81");
      go(0, 8'h01, 8'h03, EE ? 7 : 8, 1'b1, 1'b0, "a01_b03");
      go(1, 8'h06, 8'h01, EE ? 1 : 3, 1'b0, 1'b0, "w3_110_001");
      go(1, 8'h00, 8'h01, 3, 1'b1, 1'b0, "w3_000_001");

      // Asynchronous reset three edges into SCAN
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midscan_rst");
      @(negedge clk);
      #2 rst_n = 1'b1;
      go(0, 8'h05, 8'h05, 8, 1'b1, 1'b1, "after_rst_a05_b05");

      // start held through SCAN, accepted again in DONE
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hE7; b8 = 8'h81;
      @(negedge clk);
      a8 = 8'h00; b8 = 8'h00;
      begin
         int n;
         n = 0;
         while (!done8 && n < 40) begin @(negedge clk); n++; end
         chk("held_first_done", 32'(done8), 1);
         chk("held_first_z", 32'(z8), 0);
         @(negedge clk);
         start8 = 1'b0;
         chk("held_b2b_busy", 32'(busy8), 1);
         chk("held_b2b_done", 32'(done8), 0);
         chk("held_b2b_zhold", 32'(z8), 0);
         n = 0;
         while (!done8 && n < 40) begin @(negedge clk); n++; end
         chk("held_second_z", 32'(z8), 1);
         chk("held_second_eq", 32'(eq8), 1);
      end

      // Random traffic on both instances
      for (int it = 0; it < 1500; it++) begin
         @(negedge clk);
         start8 = ($urandom_range(0, 2) == 0);
         start3 = ($urandom_range(0, 2) == 0);
         a8 = 8'($urandom);
         mode = $urandom_range(0, 3);
         if (mode == 0)      b8 = a8;
         else if (mode == 1) b8 = a8 ^ (8'h01 << $urandom_range(0, 7));
         else                b8 = 8'($urandom);
         a3 = 3'($urandom);
         b3 = ($urandom_range(0, 3) == 0) ? a3 : 3'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            #1 chk_all_zero("rand_rst");
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
      end
      @(negedge clk);
      start8 = 1'b0;
      start3 = 1'b0;
      repeat (12) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_comparador_izq_der

// File: doc/comparador_izq_der.md
COMPARADOR_IZQ_DER -- requirements
Module: comparador_izq_der

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (>=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to compare wordA/wordB; sampled on rising edge.
REQ-005 SHALL have port wordA  input  WIDTH  operand A; sampled only on accepted start.
REQ-006 SHALL have port wordB  input  WIDTH  operand B; sampled only on accepted start.
REQ-007 SHALL have port z  output  1  result, 1 when A <= B (unsigned), 0 when A > B.
REQ-008 SHALL have port eq  output  1  1 when A == B.
REQ-009 SHALL have port busy  output  1  high while scanning.
REQ-010 SHALL have port done  output  1  one-cycle pulse; z/eq are valid from this cycle.

Function
REQ-011 SHALL be an FSM with states IDLE, SCAN, DONE; bits are traversed left to right, MSB first, one bit per clock.
REQ-012 SHALL accept start only in IDLE or DONE: load wordA/wordB into internal registers, set index to WIDTH-1, clear the decided flag, and enter SCAN; start in SCAN is ignored.
REQ-013 SHALL, in SCAN at each edge, compare bit[index]: if undecided and the bits differ, set decided and record ltA = (A bit == 0).
REQ-014 SHALL decrement index each SCAN edge, with no wrap-around below 0.
REQ-015 SHALL leave SCAN for DONE at the edge comparing index 0, or earlier per REQ-022.
REQ-016 SHALL, at the edge entering DONE, register z = (decided ? ltA : 1) and eq = !decided, and set done=1.
REQ-017 SHALL keep DONE for exactly one cycle, then return to IDLE unless start is accepted (back-to-back); done SHALL be high only in DONE.
REQ-018 SHALL hold z/eq unchanged from DONE until the next DONE; a new start SHALL NOT clear them.
REQ-019 SHALL set busy = 1 exactly while in SCAN; busy SHALL rise the cycle after an accepted start.
REQ-020 SHALL give latency k edges from the start edge to the done cycle: k = WIDTH without early exit; with early exit, k = position from the MSB (1-based) of the first differing bit, or WIDTH if the operands are equal.

Reset
REQ-021 SHALL, on rst_n low at any time including mid-SCAN, immediately force: state IDLE, z=0, eq=0, done=0, busy=0, index=0, operand registers 0, decided=0; start SHALL be accepted at the first edge after release.

Configuration
REQ-022 SHALL, with macro COMPARADOR_EARLY_EXIT_EN defined, enter DONE at the edge where the first differing bit is found.
REQ-023 SHALL, without COMPARADOR_EARLY_EXIT_EN, always scan all WIDTH bits, with result identical to the early-exit result.

Structure
REQ-024 SHALL take state encodings (IDLE=2'b00, SCAN=2'b01, DONE=2'b10) and the WIDTH default from shared package comparador_pkg.
REQ-025 SHALL instantiate sub-module celda_cmp_bit (1-bit combinational cell: inputs a, b; outputs diff, a_lt_b) for the per-bit compare.

Verification
REQ-026 SHALL cover WIDTH=8, A=8'h00, B=8'h00 -> done after 8 edges, z=1, eq=1 (both configurations).
REQ-027 SHALL cover WIDTH=8, A=8'hE7, B=8'h81 -> z=0, eq=0; done after 2 edges with EARLY_EXIT_EN, after 8 edges without.
REQ-028 SHALL cover WIDTH=8, A=8'h01, B=8'h03 -> z=1, eq=0; done after 7 edges with EARLY_EXIT_EN, after 8 edges without.
REQ-029 SHALL cover rst_n low asynchronously 3 edges into SCAN -> all outputs 0 immediately, then a new start with A=8'h05, B=8'h05 -> z=1, eq=1.
REQ-030 SHALL cover start held high through SCAN -> ignored, then accepted in the DONE cycle -> done 1 cycle, busy high the next cycle, z holds the prior result until the new done.
REQ-031 SHALL cover WIDTH=3, A=3'b110, B=3'b001 -> z=0 after 1 edge with EARLY_EXIT_EN; and A=3'b000, B=3'b001 -> z=1, eq=0.
